mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/mem_access_unit.sv | 164 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Pipelined Wishbone master bus used by the memory access unit.
// The unit drives the master side, the memory system the slave side.
interface mem_access_unit_if;
   logic        o_wb_cyc;
   logic        o_wb_stb;
   logic        o_wb_we;
   logic [31:0] o_wb_addr;
   logic [31:0] o_wb_data;
   logic [31:0] i_wb_data;
   logic        i_wb_ack;
   logic        i_wb_stall;

   modport master (
      output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
      input  i_wb_data, i_wb_ack, i_wb_stall
   );

   modport slave (
      input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
      output i_wb_data, i_wb_ack, i_wb_stall
   );
endinterface

// File: rtl/mem_access_unit.sv
// Arbitrates fetch and data requests onto one pipelined Wishbone master,
// one access at a time, with misalignment and timeout error reporting.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_if_req,
   input  logic [31:0] i_if_addr,
   output logic [31:0] o_if_data,
   output logic        o_if_done,
   input  logic        i_d_req,
   input  logic        i_d_we,
   input  logic [31:0] i_d_addr,
   input  logic [31:0] i_d_wdata,
   output logic [31:0] o_d_data,
   output logic        o_d_done,
   output logic        o_err,
   mem_access_unit_if.master wb
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, STROBE, WAIT_ACK, RESP} state_t;

   state_t        state, state_n;
   logic          d_pend, d_we;
   logic [31:0]   d_addr, d_wdata;
   logic          f_pend;
   logic [31:0]   f_addr;
   logic          cur_d;
   logic          bus_we;
   logic [31:0]   bus_addr, bus_wdata;
   logic [CW-1:0] cnt;
   logic          err_q;

   logic          sel_d, sel_any, sel_we;
   logic [31:0]   sel_addr, sel_wdata;
   logic          go, fin, fin_err, tmo, port_d, port_we;
   logic [31:0]   fin_data;

   // Data port wins; a slot that is already pending beats the live pulse.
   always_comb begin
      sel_d     = d_pend | i_d_req;
      sel_any   = sel_d | f_pend | i_if_req;
      sel_we    = 1'b0;
      sel_addr  = f_pend ? f_addr : i_if_addr;
      sel_wdata = '0;
      if (sel_d) begin
         sel_we    = d_pend ? d_we : i_d_we;
         sel_addr  = d_pend ? d_addr : i_d_addr;
         sel_wdata = sel_we ? (d_pend ? d_wdata : i_d_wdata) : '0;
      end
   end

   assign tmo     = (cnt == CW'(TIMEOUT_CYCLES - 1));
   assign port_d  = (state == IDLE) ? sel_d : cur_d;
   assign port_we = (state == IDLE) ? sel_we : bus_we;

   always_comb begin
      state_n  = state;
      go       = 1'b0;
      fin      = 1'b0;
      fin_err  = 1'b0;
      fin_data = '0;
      unique case (state)
         IDLE: begin
            if (sel_any) begin
               if (sel_addr[1:0] != 2'b00) begin
                  fin     = 1'b1;
                  fin_err = 1'b1;
               end else begin
                  go      = 1'b1;
                  state_n = STROBE;
               end
            end
         end
         STROBE: begin
            if (!wb.i_wb_stall && wb.i_wb_ack) begin
               fin      = 1'b1;
               fin_data = wb.i_wb_data;
            end else if (tmo) begin
               fin     = 1'b1;
               fin_err = 1'b1;
            end else if (!wb.i_wb_stall) begin
               state_n = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (wb.i_wb_ack) begin
               fin      = 1'b1;
               fin_data = wb.i_wb_data;
            end else if (tmo) begin
               fin     = 1'b1;
               fin_err = 1'b1;
            end
         end
         RESP: state_n = IDLE;
      endcase
      if (fin) state_n = RESP;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         d_pend    <= 1'b0;
         d_we      <= 1'b0;
         d_addr    <= '0;
         d_wdata   <= '0;
         f_pend    <= 1'b0;
         f_addr    <= '0;
         cur_d     <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         cnt       <= '0;
         err_q     <= 1'b0;
         o_if_data <= '0;
         o_d_data  <= '0;
      end else begin
         state <= state_n;
         err_q <= fin_err;
         if (i_d_req && !d_pend) begin
            d_pend  <= 1'b1;
            d_we    <= i_d_we;
            d_addr  <= i_d_addr;
            d_wdata <= i_d_wdata;
         end
         if (i_if_req && !f_pend) begin
            f_pend <= 1'b1;
            f_addr <= i_if_addr;
         end
         if (state == RESP) begin
            if (cur_d) d_pend <= 1'b0;
            else       f_pend <= 1'b0;
         end
         if (state == IDLE) cur_d <= sel_d;
         if (go) begin
            bus_we    <= sel_we;
            bus_addr  <= sel_addr;
            bus_wdata <= sel_wdata;
            cnt       <= '0;
         end else if (state == STROBE || state == WAIT_ACK) begin
            cnt <= cnt + CW'(1);
         end
         // Stores never disturb the last loaded word.
         if (fin) begin
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            if (!port_d)       o_if_data <= fin_data;
            else if (!port_we) o_d_data  <= fin_data;
         end
      end
   end

   assign wb.o_wb_cyc  = (state == STROBE) || (state == WAIT_ACK);
   assign wb.o_wb_stb  = (state == STROBE);
   assign wb.o_wb_we   = bus_we;
   assign wb.o_wb_addr = bus_addr;
   assign wb.o_wb_data = bus_wdata;
   assign o_if_done    = (state == RESP) && !cur_d;
   assign o_d_done     = (state == RESP) && cur_d;
   assign o_err        = err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expectations queued at issue,
// a bus responder and a completion monitor pop and compare them.
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        i_if_req, i_d_req, i_d_we;
   logic [31:0] i_if_addr, i_d_addr, i_d_wdata;
   logic [31:0] o_if_data, o_d_data;
   logic        o_if_done, o_d_done, o_err;

   mem_access_unit_if wb();

   mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .i_if_req(i_if_req), .i_if_addr(i_if_addr),
      .o_if_data(o_if_data), .o_if_done(o_if_done),
      .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr),
      .i_d_wdata(i_d_wdata), .o_d_data(o_d_data), .o_d_done(o_d_done),
      .o_err(o_err), .wb(wb)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic        chk;
      int          due;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      int          stall;
      logic        ack;
      logic [31:0] rdata;
   } bus_t;

   exp_t dq[$];
   exp_t fq[$];
   bus_t bq[$];
   int   tests = 0;
   int   fails = 0;
   int   cycnt = 0;
   int   cyc_cnt = 0;
   int   stb_cnt = 0;
   logic force_ack = 1'b0;

   task automatic check(input string nm, input bit ok, input string msg);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: %s", nm, msg);
      end
   endtask

   task automatic done_chk(input string nm, input logic [31:0] d,
                           input logic e, input exp_t x);
      bit ok;
      ok = (e == x.err) && (!x.chk || d == x.data) &&
           (x.due == 0 || cycnt == x.due);
      check(nm, ok, $sformatf(
         "got data=%h err=%0d cycle=%0d, required data=%h err=%0d cycle=%0d",
         d, e, cycnt, x.data, x.err, x.due));
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue_d(input logic we, input logic [31:0] a,
                          input logic [31:0] wd);
      i_d_req = 1'b1; i_d_we = we; i_d_addr = a; i_d_wdata = wd;
      tick();
      i_d_req = 1'b0; i_d_we = 1'b0; i_d_addr = '0; i_d_wdata = '0;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while ((dq.size() != 0 || fq.size() != 0 || bq.size() != 0 ||
              wb.o_wb_cyc) && n < 40) begin
         tick();
         n++;
      end
      tick(2);
      check(nm, dq.size() == 0 && fq.size() == 0 && bq.size() == 0,
            $sformatf("left d=%0d f=%0d bus=%0d, required all 0",
                      dq.size(), fq.size(), bq.size()));
   endtask

   initial forever begin
      @(posedge clk);
      cycnt++;
   end

   // Slave model: pops the expected transfer at the first strobe.
   initial begin
      bus_t        cur;
      logic        have;
      int          stall_left;
      logic [64:0] snap;
      cur = '{default: '0};
      have = 1'b0;
      stall_left = 0;
      snap = '0;
      wb.i_wb_ack = 1'b0;
      wb.i_wb_stall = 1'b0;
      wb.i_wb_data = 32'h5a5a5a5a;
      forever begin
         @(negedge clk);
         if (wb.o_wb_cyc && wb.o_wb_stb) begin
            cyc_cnt++;
            stb_cnt++;
            if (!have) begin
               if (bq.size() == 0) begin
                  check("bus_unexpected", 1'b0, $sformatf(
                     "got strobe addr=%h, required no transfer",
                     wb.o_wb_addr));
                  cur = '{default: '0};
               end else begin
                  cur = bq.pop_front();
                  check("bus_req",
                        wb.o_wb_addr == cur.addr && wb.o_wb_we == cur.we &&
                        wb.o_wb_data == cur.wdata, $sformatf(
                        "got addr=%h we=%0d data=%h, required %h %0d %h",
                        wb.o_wb_addr, wb.o_wb_we, wb.o_wb_data,
                        cur.addr, cur.we, cur.wdata));
               end
               have = 1'b1;
               stall_left = cur.stall;
            end else begin
               check("stb_stable",
                     {wb.o_wb_addr, wb.o_wb_we, wb.o_wb_data} == snap,
                     $sformatf("got %h, required %h",
                     {wb.o_wb_addr, wb.o_wb_we, wb.o_wb_data}, snap));
            end
            snap = {wb.o_wb_addr, wb.o_wb_we, wb.o_wb_data};
            wb.i_wb_ack = 1'b0;
            wb.i_wb_data = 32'h5a5a5a5a;
            if (stall_left > 0) begin
               wb.i_wb_stall = 1'b1;
               stall_left--;
            end else begin
               wb.i_wb_stall = 1'b0;
            end
         end else if (wb.o_wb_cyc) begin
            cyc_cnt++;
            wb.i_wb_stall = 1'b0;
            wb.i_wb_ack = cur.ack;
            wb.i_wb_data = cur.rdata;
         end else begin
            have = 1'b0;
            wb.i_wb_stall = force_ack;
            wb.i_wb_ack = force_ack;
            wb.i_wb_data = 32'hffffffff;
         end
      end
   end

   // Completion monitor.
   initial forever begin
      exp_t x;
      @(negedge clk);
      if (o_d_done && o_if_done)
         check("dual_done", 1'b0, "got both done pulses, required one");
      if (o_d_done) begin
         if (dq.size() == 0)
            check("d_done_unexpected", 1'b0, $sformatf(
               "got done data=%h err=%0d, required none", o_d_data, o_err));
         else begin
            x = dq.pop_front();
            done_chk("d_done", o_d_data, o_err, x);
         end
      end
      if (o_if_done) begin
         if (fq.size() == 0)
            check("if_done_unexpected", 1'b0, $sformatf(
               "got done data=%h err=%0d, required none", o_if_data, o_err));
         else begin
            x = fq.pop_front();
            done_chk("if_done", o_if_data, o_err, x);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int c0;
      logic [31:0] last_d;
      reset = 1'b1;
      i_if_req = 1'b1; i_if_addr = 32'hb0000000;
      i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'hb0000000;
      i_d_wdata = '0;
      tick(3);
      @(negedge clk);
      check("reset_outputs",
            {o_if_data, o_d_data, o_if_done, o_d_done, o_err, wb.o_wb_cyc,
             wb.o_wb_stb, wb.o_wb_we, wb.o_wb_addr, wb.o_wb_data} == '0,
            $sformatf("got cyc=%0d stb=%0d done=%0d/%0d, required all 0",
                      wb.o_wb_cyc, wb.o_wb_stb, o_if_done, o_d_done));
      tick();
      reset = 1'b0;
      i_if_req = 1'b0; i_d_req = 1'b0; i_if_addr = '0; i_d_addr = '0;
      tick(3);
      check("reset_no_bus", cyc_cnt == 0,
            $sformatf("got %0d bus cycles, required 0", cyc_cnt));

      // Fetch, second pulse while pending is dropped.
      k = cycnt;
      bq.push_back('{32'hb0000000, 1'b0, 32'h0, 0, 1'b1, 32'h1234abcd});
      fq.push_back('{32'h1234abcd, 1'b0, 1'b1, k + 3});
      i_if_req = 1'b1; i_if_addr = 32'hb0000000;
      tick();
      i_if_addr = 32'hb0000100;
      tick();
      i_if_req = 1'b0; i_if_addr = '0;
      drain("fetch_drain");

      k = cycnt;
      last_d = 32'hcafef00d;
      bq.push_back('{32'hb0000040, 1'b0, 32'h0, 0, 1'b1, 32'hcafef00d});
      dq.push_back('{32'hcafef00d, 1'b0, 1'b1, k + 3});
      issue_d(1'b0, 32'hb0000040, 32'h0);
      drain("load_drain");

      // Store with three stall cycles; load data must stay put.
      k = cycnt;
      c0 = stb_cnt;
      bq.push_back('{32'hb000fffc, 1'b1, 32'hdeadbeef, 3, 1'b1, 32'h11111111});
      dq.push_back('{last_d, 1'b0, 1'b1, k + 6});
      issue_d(1'b1, 32'hb000fffc, 32'hdeadbeef);
      drain("store_drain");
      check("store_stb_cycles", stb_cnt - c0 == 4,
            $sformatf("got %0d, required 4", stb_cnt - c0));

      // Simultaneous requests: data first, fetch after one idle cycle.
      k = cycnt;
      bq.push_back('{32'hb0000010, 1'b0, 32'h0, 0, 1'b1, 32'h0badf00d});
      bq.push_back('{32'hb0000020, 1'b0, 32'h0, 0, 1'b1, 32'h600dcafe});
      dq.push_back('{32'h0badf00d, 1'b0, 1'b1, k + 3});
      fq.push_back('{32'h600dcafe, 1'b0, 1'b1, k + 7});
      i_if_req = 1'b1; i_if_addr = 32'hb0000020;
      i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'hb0000010;
      tick();
      i_if_req = 1'b0; i_d_req = 1'b0; i_if_addr = '0; i_d_addr = '0;
      drain("dual_drain");

      k = cycnt;
      c0 = cyc_cnt;
      dq.push_back('{32'h0, 1'b1, 1'b0, k + 1});
      issue_d(1'b0, 32'hb0000002, 32'h0);
      drain("misalign_drain");
      check("misalign_no_cyc", cyc_cnt == c0,
            $sformatf("got %0d cyc cycles, required 0", cyc_cnt - c0));

      k = cycnt;
      c0 = cyc_cnt;
      bq.push_back('{32'hb0000080, 1'b0, 32'h0, 0, 1'b0, 32'h77777777});
      dq.push_back('{32'h0, 1'b1, 1'b1, k + 9});
      issue_d(1'b0, 32'hb0000080, 32'h0);
      drain("timeout_drain");
      check("timeout_cyc_len", cyc_cnt - c0 == 8,
            $sformatf("got %0d, required 8", cyc_cnt - c0));

      // Reset while waiting for an ack that never comes.
      bq.push_back('{32'hb00000c0, 1'b0, 32'h0, 0, 1'b0, 32'h0});
      issue_d(1'b0, 32'hb00000c0, 32'h0);
      tick();
      check("wait_ack_state", wb.o_wb_cyc && !wb.o_wb_stb,
            $sformatf("got cyc=%0d stb=%0d, required 1 0",
                      wb.o_wb_cyc, wb.o_wb_stb));
      reset = 1'b1;
      tick();
      @(negedge clk);
      check("reset_inflight",
            {o_if_data, o_d_data, o_if_done, o_d_done, o_err, wb.o_wb_cyc,
             wb.o_wb_stb, wb.o_wb_we, wb.o_wb_addr, wb.o_wb_data} == '0,
            $sformatf("got cyc=%0d if_data=%h addr=%h, required all 0",
                      wb.o_wb_cyc, o_if_data, wb.o_wb_addr));
      tick();
      reset = 1'b0;
      force_ack = 1'b1;
      tick(4);
      force_ack = 1'b0;
      tick(2);
      check("reset_bus_consumed", bq.size() == 0,
            $sformatf("got %0d queued, required 0", bq.size()));

      k = cycnt;
      bq.push_back('{32'hb0000004, 1'b0, 32'h0, 0, 1'b1, 32'h13579bdf});
      dq.push_back('{32'h13579bdf, 1'b0, 1'b1, k + 3});
      issue_d(1'b0, 32'hb0000004, 32'h0);
      drain("recover_load");

      k = cycnt;
      bq.push_back('{32'hb0000008, 1'b0, 32'h0, 1, 1'b1, 32'h2468ace0});
      fq.push_back('{32'h2468ace0, 1'b0, 1'b1, k + 4});
      i_if_req = 1'b1; i_if_addr = 32'hb0000008;
      tick();
      i_if_req = 1'b0; i_if_addr = '0;
      drain("recover_fetch");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
